// File: rtl/tof_result_collector_pkg.sv
// rtl/tof_result_collector_pkg.sv - shared ToF sample layout, scan state type and index helper
package tof_result_collector_pkg;

  localparam int TOF_SENSOR_W   = 3;
  localparam int TOF_ZONE_W     = 6;
  localparam int TOF_DIST_W     = 16;
  localparam int TOF_SAMPLE_W   = 25;
  localparam int TOF_DIST_LSB   = 0;
  localparam int TOF_ZONE_LSB   = 16;
  localparam int TOF_SENSOR_LSB = 22;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  // Next masked-in index above cur (wrapping); a masked-out cur restarts at the lowest one.
  function automatic logic [2:0] tof_next_index(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] lowest;
    logic [2:0] above;
    logic       found;
    lowest = cur;
    above  = cur;
    found  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[3'(i)]) begin
        lowest = 3'(i);
        if (i > int'(cur)) begin
          above = 3'(i);
          found = 1'b1;
        end
      end
    end
    if (!mask[cur] || !found) return lowest;
    return above;
  endfunction

endpackage

// File: rtl/tof_sample_fifo.sv
// rtl/tof_sample_fifo.sv - single-clock sample FIFO with registered storage and occupancy level
module tof_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 25,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // The extra pointer bit separates full from empty when the low bits match.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tof_result_collector.sv
// rtl/tof_result_collector.sv - round-robin ToF ready-flag scanner feeding a tagged sample FIFO
module tof_result_collector
  import tof_result_collector_pkg::*;
#(
  parameter int NB_OF_SENSORS = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    sensor_mask,
  input  logic [7:0]                    ready_in,
  input  logic [21:0]                   data_in,
  output logic [2:0]                    tof_index,
  output logic [TOF_SAMPLE_W-1:0]       m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          overflow,
  input  logic                          clr_stats
);

  localparam logic [7:0] VALID_MASK = 8'((1 << NB_OF_SENSORS) - 1);

  scan_state_t             state_q;
  scan_state_t             state_d;
  logic [7:0]              eff_mask;
  logic [2:0]              index_d;
  logic                    sample;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [TOF_SAMPLE_W-1:0] push_word;

  assign eff_mask = sensor_mask & VALID_MASK;

  always_comb begin
    state_d = ST_IDLE;
    index_d = tof_index;
    sample  = 1'b0;
    if (enable && eff_mask != 8'd0) state_d = ST_SCAN;
    if (state_q == ST_SCAN) begin
      sample = ready_in[tof_index] & eff_mask[tof_index];
      if (eff_mask != 8'd0) index_d = tof_next_index(tof_index, eff_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tof_index <= 3'd0;
    end else begin
      state_q   <= state_d;
      tof_index <= index_d;
    end
  end

  always_comb begin
    push_word = '0;
    push_word[TOF_SENSOR_LSB +: TOF_SENSOR_W] = tof_index;
    push_word[TOF_ZONE_LSB +: TOF_ZONE_W]     = data_in[TOF_ZONE_LSB +: TOF_ZONE_W];
    push_word[TOF_DIST_LSB +: TOF_DIST_W]     = data_in[TOF_DIST_LSB +: TOF_DIST_W];
  end

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign pop     = m_valid & m_ready;
  assign push    = sample & (~fifo_full | pop);
  assign drop    = sample & fifo_full & ~pop;
  assign m_valid = ~fifo_empty;

  tof_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TOF_SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      overflow <= 1'b1;
    end
  end

endmodule

// File: doc/tof_result_collector.md
Name: tof_result_collector

Overview:
- Consumer stage directly downstream of the per-sensor I2C/ToF communication array.
- Scans the 8 sticky per-sensor ready flags round-robin and drives the sensor select index back to that array.
- Captures the muxed {zone index, distance} word of a ready sensor and tags it with the sensor number.
- Pushes the tagged sample into a FIFO drained by a valid/ready stream toward the host link (UART/SPI bridge), and counts samples lost to FIFO overflow.

Parameters:
- NB_OF_SENSORS, 8: number of scanned sensors (1..8); indices >= NB_OF_SENSORS are never selected.
- FIFO_DEPTH, 16: sample FIFO depth; power of two, 2..256.
- CNT_W, 16: width of the saturating drop counter.

Ports:
- clk  in  1  system clock, same clock as the ToF FSMs.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; 0 freezes the scan index and suppresses pushes.
- sensor_mask  in  8  bit i = 1 means sensor i is scanned.
- ready_in  in  8  sticky per-sensor data-ready flags. Set by the sensor FSM; cleared one cycle after this block selects that index.
- data_in  in  22  {zone[21:16], distance[15:0]} for the currently selected sensor; combinational from tof_index.
- tof_index  out  3  registered sensor select.
- m_data  out  25  {sensor[24:22], zone[21:16], distance[15:0]}.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  downstream accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_count  out  CNT_W  saturating count of lost samples.
- overflow  out  1  sticky; set on first drop, cleared only by reset or clr_stats.
- clr_stats  in  1  synchronous pulse; zeroes drop_count and overflow.

Behaviour:
- Reset values: tof_index = 0, m_valid = 0, fifo_level = 0, drop_count = 0, overflow = 0, FIFO pointers = 0. m_data is don't-care while m_valid = 0.
- Scan state (IDLE/SCAN, 2 states):
  - IDLE when enable = 0 or (sensor_mask & valid-sensor mask) == 0; tof_index holds.
  - SCAN otherwise. Each cycle tof_index advances to the next masked-in index above the current one, wrapping mod NB_OF_SENSORS.
  - If the current index is masked out, it jumps to the lowest masked-in index.
  - A full round therefore takes popcount(mask) cycles.
- Capture: in SCAN, a sample is present when ready_in[tof_index] = 1 and sensor_mask[tof_index] = 1.
  - The push word {tof_index, data_in} is sampled at that same clock edge.
  - Every sample present yields exactly one push or one drop; a flag still high on the next visit is a new sample.
- Push and pop rules:
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Pop occurs when m_valid & m_ready.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Drop: a sample present while the FIFO is full with no pop gives drop_count += 1 (saturating at all ones) and overflow = 1. Scanning continues; the upstream flag is cleared by selection anyway.
- Latency: a pushed sample appears on m_data/m_valid one cycle after the push edge (registered FIFO). m_data is held stable while m_valid = 1 and m_ready = 0.
- Ordering: FIFO is strict first-in first-out; pointers wrap mod FIFO_DEPTH; full/empty use an extra pointer bit.
- enable falling mid-scan: any push in that cycle completes; tof_index then freezes, and FIFO drain continues.
- sensor_mask change takes effect on the next index computation.
- clr_stats coinciding with a drop: clear wins and drop_count = 0.
- Reset mid-operation: FIFO contents are discarded and all outputs return to reset values asynchronously.

Decomposition:
- Shared package: TOF_SENSOR_W = 3, TOF_ZONE_W = 6, TOF_DIST_W = 16, TOF_SAMPLE_W = 25, and the sample field offsets. The same package is used by the host bridge.
- One sub-module, tof_sample_fifo: single-clock register/BRAM FIFO with push/pop/full/empty/level.
- The scan FSM and drop counter stay in the top block.

Test Plan:
- Reset, mask = 0xFF, enable = 1, no ready flags -> tof_index cycles 0..7 repeatedly, m_valid = 0, drop_count = 0.
- ready_in[5] set with data_in = {6'd12, 16'd1234} when tof_index = 5 -> one cycle later m_valid = 1 and m_data = {3'd5, 6'd12, 16'd1234}; exactly one entry.
- mask = 8'b0010_0100 -> tof_index alternates 2,5,2,5; ready on sensor 3 is never captured.
- m_ready = 0, all 8 flags held high, FIFO_DEPTH = 16 -> fifo_level reaches 16. Then every further visit increments drop_count and overflow = 1. Releasing m_ready drains the 16 entries in push order.
- FIFO full with m_ready = 1 and a sample present in the same cycle -> push accepted, fifo_level stays 16, drop_count unchanged.
- Assert reset while fifo_level = 7 mid-scan -> m_valid = 0, fifo_level = 0 and tof_index = 0 immediately (asynchronously); clr_stats pulse -> drop_count = 0, overflow = 0.
